// File: rtl/rv_pkg.sv
// Shared RV32I pipeline definitions: load/store size codes, MEM-stage FSM states
// and small address-alignment helpers used by the memory stage.
package rv_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [4:0] REG_X0 = 5'd0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUS  = 1'b1
    } mem_state_t;

    // Byte offset actually used on the bus: halves and words snap to natural alignment.
    function automatic logic [1:0] align_offset(input logic [2:0] funct3, input logic [1:0] a);
        case (funct3[1:0])
            2'b00:   return a;
            2'b01:   return a & 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] a);
        case (funct3[1:0])
            2'b01:   return a[0];
            2'b10:   return |a;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/load_align.sv
// Combinational load extractor: picks the byte/half of the bus word at the given
// offset and sign- or zero-extends it according to funct3.
module load_align
    import rv_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [7:0]  lane [4];
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign lane[gi] = rdata[8*gi +: 8];
    end

    always_comb begin
        byte_sel = lane[addr];
        half_sel = addr[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            F3_B:    data = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   data = {24'h000000, byte_sel};
            F3_H:    data = {{16{half_sel[15]}}, half_sel};
            F3_HU:   data = {16'h0000, half_sel};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// RV32I MEM stage: MEM/WB slots, single-outstanding req/ack data bus, forwarding outputs.
// Optional MEM_MISALIGN_TRAP_EN: misaligned H/W accesses skip the bus and raise misalign_err.
module mem_stage
    import rv_pkg::*;
#(
    parameter logic [4:0] RESET_DEST = 5'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic [31:0] ex_result,
    input  logic [31:0] ex_store_data,
    input  logic [4:0]  ex_dest,
    input  logic        ex_write_enable,
    input  logic        ex_mem_read,
    input  logic        ex_mem_write,
    input  logic [2:0]  ex_funct3,
    output logic        stall,
    output logic        dbus_req,
    output logic        dbus_we,
    output logic [31:0] dbus_addr,
    output logic [31:0] dbus_wdata,
    output logic [3:0]  dbus_wstrb,
    input  logic        dbus_ack,
    input  logic [31:0] dbus_rdata,
    output logic [4:0]  mem_dest,
    output logic        mem_write_enable,
    output logic [31:0] mem_data,
    output logic [4:0]  wb_dest,
    output logic        wb_write_enable,
`ifdef MEM_MISALIGN_TRAP_EN
    output logic        misalign_err,
`endif
    output logic [31:0] wb_data
);

    mem_state_t  state_reg, state_next;

    logic [31:0] slot_result_reg;
    logic [31:0] slot_sdata_reg;
    logic [4:0]  slot_dest_reg;
    logic        slot_we_reg;
    logic        slot_rd_reg;
    logic        slot_wr_reg;
    logic [2:0]  slot_f3_reg;

    logic [4:0]  wb_dest_reg;
    logic        wb_we_reg;
    logic [31:0] wb_data_reg;

    logic        bus_active;
    logic        advance;
    logic        ex_is_mem;
    logic        ex_go;
    logic        ex_we;
    logic [1:0]  offset;
    logic [31:0] load_data;

    assign bus_active = (state_reg == ST_BUS);
    assign stall      = bus_active && !dbus_ack;
    assign advance    = !stall;
    assign ex_is_mem  = ex_valid && (ex_mem_read || ex_mem_write);

`ifdef MEM_MISALIGN_TRAP_EN
    logic ex_mis;
    logic slot_mis_reg;
    logic mis_err_reg;

    assign ex_mis = ex_is_mem && is_misaligned(ex_funct3, ex_result[1:0]);
    assign ex_go  = ex_is_mem && !ex_mis;
    assign ex_we  = ex_valid && ex_write_enable && !ex_mem_write
                    && (ex_dest != REG_X0) && !ex_mis;
`else
    assign ex_go  = ex_is_mem;
    assign ex_we  = ex_valid && ex_write_enable && !ex_mem_write && (ex_dest != REG_X0);
`endif

    // An access completes on ack; the same edge captures the next EX op.
    always_comb begin
        state_next = state_reg;
        if (advance) begin
            state_next = ex_go ? ST_BUS : ST_IDLE;
        end
    end

    assign offset = align_offset(slot_f3_reg, slot_result_reg[1:0]);

    always_comb begin
        dbus_req   = bus_active;
        dbus_we    = 1'b0;
        dbus_addr  = 32'h0;
        dbus_wdata = 32'h0;
        dbus_wstrb = 4'b0000;
        if (bus_active) begin
            dbus_addr = {slot_result_reg[31:2], 2'b00};
            if (slot_wr_reg) begin
                dbus_we = 1'b1;
                case (slot_f3_reg[1:0])
                    2'b00: begin
                        dbus_wdata = {4{slot_sdata_reg[7:0]}};
                        dbus_wstrb = 4'b0001 << offset;
                    end
                    2'b01: begin
                        dbus_wdata = {2{slot_sdata_reg[15:0]}};
                        dbus_wstrb = 4'b0011 << offset;
                    end
                    default: begin
                        dbus_wdata = slot_sdata_reg;
                        dbus_wstrb = 4'b1111;
                    end
                endcase
            end
        end
    end

    load_align u_load_align (
        .rdata  (dbus_rdata),
        .addr   (offset),
        .funct3 (slot_f3_reg),
        .data   (load_data)
    );

    // A load's result only exists in its ack cycle.
    assign mem_write_enable = slot_we_reg && (!slot_rd_reg || (bus_active && dbus_ack));
    assign mem_data         = slot_rd_reg ? load_data : slot_result_reg;
    assign mem_dest         = slot_dest_reg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg       <= ST_IDLE;
            slot_result_reg <= 32'h0;
            slot_sdata_reg  <= 32'h0;
            slot_dest_reg   <= RESET_DEST;
            slot_we_reg     <= 1'b0;
            slot_rd_reg     <= 1'b0;
            slot_wr_reg     <= 1'b0;
            slot_f3_reg     <= 3'b000;
            wb_dest_reg     <= RESET_DEST;
            wb_we_reg       <= 1'b0;
            wb_data_reg     <= 32'h0;
        end else begin
            state_reg <= state_next;
            if (advance) begin
                slot_result_reg <= ex_valid ? ex_result : 32'h0;
                slot_sdata_reg  <= ex_store_data;
                slot_dest_reg   <= ex_dest;
                slot_we_reg     <= ex_we;
                slot_rd_reg     <= ex_go && ex_mem_read;
                slot_wr_reg     <= ex_go && ex_mem_write;
                slot_f3_reg     <= ex_funct3;
                wb_dest_reg     <= slot_dest_reg;
                wb_we_reg       <= mem_write_enable;
                wb_data_reg     <= mem_data;
            end
        end
    end

`ifdef MEM_MISALIGN_TRAP_EN
    // The error flag follows its instruction into WB but is only a one-cycle pulse.
    always_ff @(posedge clk) begin
        if (!rst) begin
            slot_mis_reg <= 1'b0;
            mis_err_reg  <= 1'b0;
        end else begin
            mis_err_reg <= advance && slot_mis_reg;
            if (advance) begin
                slot_mis_reg <= ex_mis;
            end
        end
    end

    assign misalign_err = mis_err_reg;
`endif

    assign wb_dest         = wb_dest_reg;
    assign wb_write_enable = wb_we_reg;
    assign wb_data         = wb_data_reg;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: vector table of memory/ALU ops fed through an
// issue queue, a scoreboard of in-flight expectations, and a reactive bus responder.
module tb_mem_stage;

    localparam logic [4:0] RST_DEST = 5'd3;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic [31:0] ex_result;
    logic [31:0] ex_store_data;
    logic [4:0]  ex_dest;
    logic        ex_write_enable;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic [2:0]  ex_funct3;
    logic        stall;
    logic        dbus_req;
    logic        dbus_we;
    logic [31:0] dbus_addr;
    logic [31:0] dbus_wdata;
    logic [3:0]  dbus_wstrb;
    logic        dbus_ack;
    logic [31:0] dbus_rdata;
    logic [4:0]  mem_dest;
    logic        mem_write_enable;
    logic [31:0] mem_data;
    logic [4:0]  wb_dest;
    logic        wb_write_enable;
    logic [31:0] wb_data;
`ifdef MEM_MISALIGN_TRAP_EN
    logic        misalign_err;
`endif

    always #5 clk = ~clk;

    mem_stage #(.RESET_DEST(RST_DEST)) dut (
        .clk              (clk),
        .rst              (rst),
        .ex_valid         (ex_valid),
        .ex_result        (ex_result),
        .ex_store_data    (ex_store_data),
        .ex_dest          (ex_dest),
        .ex_write_enable  (ex_write_enable),
        .ex_mem_read      (ex_mem_read),
        .ex_mem_write     (ex_mem_write),
        .ex_funct3        (ex_funct3),
        .stall            (stall),
        .dbus_req         (dbus_req),
        .dbus_we          (dbus_we),
        .dbus_addr        (dbus_addr),
        .dbus_wdata       (dbus_wdata),
        .dbus_wstrb       (dbus_wstrb),
        .dbus_ack         (dbus_ack),
        .dbus_rdata       (dbus_rdata),
        .mem_dest         (mem_dest),
        .mem_write_enable (mem_write_enable),
        .mem_data         (mem_data),
        .wb_dest          (wb_dest),
        .wb_write_enable  (wb_write_enable),
`ifdef MEM_MISALIGN_TRAP_EN
        .misalign_err     (misalign_err),
`endif
        .wb_data          (wb_data)
    );

    typedef struct {
        string       name;
        bit          valid;
        bit          rd;
        bit          wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [31:0] rdata;
        logic [4:0]  dest;
        int          waits;
        bit          exp_we;
        logic [31:0] exp_data;
        logic [31:0] exp_baddr;
        logic [31:0] exp_wdata;
        logic [3:0]  exp_strb;
        bit          exp_mis;
        bit          chk_all;
    } vec_t;

    vec_t        issue_q[$];
    vec_t        exp_q[$];
    vec_t        wb_exp;
    vec_t        tbl[16];
    bit          wb_check = 1'b0;
    bit          exp_mis_now = 1'b0;
    int          waits = 0;
    int          checks = 0;
    int          errors = 0;
    bit          prev_req = 1'b0;
    logic [31:0] prev_addr = 32'h0;
    int          b2b = 0;

    function automatic vec_t mk(input string name, input bit rd, input bit wr, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] sdata,
                                input logic [31:0] rdata, input logic [4:0] dest, input int wt,
                                input bit exp_we, input logic [31:0] exp_data,
                                input logic [31:0] exp_baddr, input logic [31:0] exp_wdata,
                                input logic [3:0] exp_strb, input bit exp_mis);
        vec_t v;
        v.name = name; v.valid = 1'b1; v.rd = rd; v.wr = wr; v.f3 = f3;
        v.addr = addr; v.sdata = sdata; v.rdata = rdata; v.dest = dest; v.waits = wt;
        v.exp_we = exp_we; v.exp_data = exp_data; v.exp_baddr = exp_baddr;
        v.exp_wdata = exp_wdata; v.exp_strb = exp_strb; v.exp_mis = exp_mis; v.chk_all = 1'b0;
        return v;
    endfunction

    function automatic vec_t bubble();
        vec_t v;
        v = mk("bubble", 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 5'd0, 0,
               1'b0, 32'h0, 32'h0, 32'h0, 4'h0, 1'b0);
        v.valid = 1'b0;
        return v;
    endfunction

    function automatic vec_t rst_item();
        vec_t v;
        v = bubble();
        v.name = "reset"; v.dest = RST_DEST; v.chk_all = 1'b1;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    // One pipeline cycle: drive, check at negedge, then advance the reference pipeline.
    task automatic step(input bit do_rst, input bit force_ack);
        vec_t ex;
        vec_t mem;
        bit   bus_mem, ack, exp_stall, mem_we_exp;
        ex = (issue_q.size() != 0 && !do_rst) ? issue_q[0] : bubble();
        ex_valid        = ex.valid;
        ex_result       = ex.addr;
        ex_store_data   = ex.sdata;
        ex_dest         = ex.dest;
        ex_write_enable = ex.valid;
        ex_mem_read     = ex.rd;
        ex_mem_write    = ex.wr;
        ex_funct3       = ex.f3;
        rst             = !do_rst;
        mem        = exp_q[0];
        bus_mem    = mem.valid && (mem.rd || mem.wr) && !mem.exp_mis;
        ack        = force_ack || (bus_mem && waits >= mem.waits);
        dbus_ack   = ack;
        dbus_rdata = (bus_mem && ack) ? mem.rdata : $urandom;
        exp_stall  = bus_mem && !ack;
        mem_we_exp = mem.exp_we && (!mem.rd || ack);
        @(negedge clk);
        chk({mem.name, " stall"}, 32'(stall), 32'(exp_stall));
        chk({mem.name, " dbus_req"}, 32'(dbus_req), 32'(bus_mem));
        if (bus_mem) begin
            chk({mem.name, " dbus_addr"}, dbus_addr, mem.exp_baddr);
            chk({mem.name, " dbus_we"}, 32'(dbus_we), 32'(mem.wr));
            if (mem.wr) begin
                chk({mem.name, " dbus_wstrb"}, 32'(dbus_wstrb), 32'(mem.exp_strb));
                chk({mem.name, " dbus_wdata"}, dbus_wdata, mem.exp_wdata);
            end
        end
        if (mem.chk_all) begin
            chk("reset dbus_we", 32'(dbus_we), 32'h0);
            chk("reset dbus_wstrb", 32'(dbus_wstrb), 32'h0);
            chk("reset dbus_addr", dbus_addr, 32'h0);
            chk("reset dbus_wdata", dbus_wdata, 32'h0);
            chk("reset mem_dest", 32'(mem_dest), 32'(RST_DEST));
            chk("reset mem_data", mem_data, 32'h0);
        end
        chk({mem.name, " mem_we"}, 32'(mem_write_enable), 32'(mem_we_exp));
        if (mem_we_exp) begin
            chk({mem.name, " mem_data"}, mem_data, mem.exp_data);
            chk({mem.name, " mem_dest"}, 32'(mem_dest), 32'(mem.dest));
        end
        if (wb_check) begin
            chk({wb_exp.name, " wb_we"}, 32'(wb_write_enable), 32'(wb_exp.exp_we));
            if (wb_exp.exp_we) begin
                chk({wb_exp.name, " wb_data"}, wb_data, wb_exp.exp_data);
                chk({wb_exp.name, " wb_dest"}, 32'(wb_dest), 32'(wb_exp.dest));
            end
            if (wb_exp.chk_all) begin
                chk("reset wb_dest", 32'(wb_dest), 32'(RST_DEST));
                chk("reset wb_data", wb_data, 32'h0);
            end
`ifdef MEM_MISALIGN_TRAP_EN
            chk({wb_exp.name, " misalign_err"}, 32'(misalign_err), 32'(exp_mis_now));
`endif
        end
        if (dbus_req && prev_req && dbus_addr != prev_addr) b2b++;
        prev_req  = dbus_req;
        prev_addr = dbus_addr;
        @(posedge clk);
        #1;
        if (do_rst) begin
            exp_q.delete();
            exp_q.push_back(rst_item());
            wb_exp      = rst_item();
            exp_mis_now = 1'b0;
            waits       = 0;
            $display("reset applied");
        end else if (!exp_stall) begin
            wb_exp = exp_q.pop_front();
            exp_q.push_back(ex);
            if (issue_q.size() != 0) void'(issue_q.pop_front());
            if (ex.valid) $display("issue  %s addr=%h", ex.name, ex.addr);
            if (wb_exp.valid) $display("retire %s we=%0d data=%h", wb_exp.name, wb_exp.exp_we, wb_exp.exp_data);
            exp_mis_now = wb_exp.exp_mis;
            waits       = 0;
        end else begin
            waits++;
            exp_mis_now = 1'b0;
        end
        wb_check = 1'b1;
    endtask

    task automatic drain();
        int n = 0;
        while (issue_q.size() != 0 && n < 100) begin
            step(1'b0, 1'b0);
            n++;
        end
        if (issue_q.size() != 0) begin
            chk("drain_timeout", 32'(issue_q.size()), 32'h0);
            issue_q.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t bub;
        tbl[0]  = mk("alu",    0, 0, 3'b000, 32'h0000_1234, 32'h0, 32'h0, 5'd5, 0, 1, 32'h0000_1234, 32'h0, 32'h0, 4'h0, 0);
        tbl[1]  = mk("lb",     1, 0, 3'b000, 32'h0000_0103, 32'h0, 32'h80FF_FF7F, 5'd6, 2, 1, 32'hFFFF_FF80, 32'h100, 32'h0, 4'h0, 0);
        tbl[2]  = mk("lbu",    1, 0, 3'b100, 32'h0000_0103, 32'h0, 32'h80FF_FF7F, 5'd6, 2, 1, 32'h0000_0080, 32'h100, 32'h0, 4'h0, 0);
        tbl[3]  = mk("sh",     0, 1, 3'b001, 32'h0000_0202, 32'hAAAA_BEEF, 32'h0, 5'd7, 0, 0, 32'h0, 32'h200, 32'hBEEF_BEEF, 4'b1100, 0);
        tbl[4]  = mk("lw",     1, 0, 3'b010, 32'h0000_0300, 32'h0, 32'hDEAD_BEEF, 5'd8, 0, 1, 32'hDEAD_BEEF, 32'h300, 32'h0, 4'h0, 0);
        tbl[5]  = mk("sw",     0, 1, 3'b010, 32'h0000_0304, 32'h0123_4567, 32'h0, 5'd9, 0, 0, 32'h0, 32'h304, 32'h0123_4567, 4'b1111, 0);
        tbl[6]  = mk("lh",     1, 0, 3'b001, 32'h0000_0402, 32'h0, 32'h8001_7FFF, 5'd10, 1, 1, 32'hFFFF_8001, 32'h400, 32'h0, 4'h0, 0);
        tbl[7]  = mk("lhu",    1, 0, 3'b101, 32'h0000_0400, 32'h0, 32'h8001_7FFF, 5'd11, 0, 1, 32'h0000_7FFF, 32'h400, 32'h0, 4'h0, 0);
        tbl[8]  = mk("sb",     0, 1, 3'b000, 32'h0000_0501, 32'h1234_565A, 32'h0, 5'd1, 1, 0, 32'h0, 32'h500, 32'h5A5A_5A5A, 4'b0010, 0);
        tbl[9]  = mk("alu_x0", 0, 0, 3'b000, 32'h0000_0055, 32'h0, 32'h0, 5'd0, 0, 0, 32'h0, 32'h0, 32'h0, 4'h0, 0);
        tbl[10] = mk("lb_x0",  1, 0, 3'b000, 32'h0000_0600, 32'h0, 32'h0000_0012, 5'd0, 0, 0, 32'h0, 32'h600, 32'h0, 4'h0, 0);
`ifdef MEM_MISALIGN_TRAP_EN
        tbl[11] = mk("lw_mis", 1, 0, 3'b010, 32'h0000_0101, 32'h0, 32'hCAFE_F00D, 5'd12, 1, 0, 32'h0, 32'h0, 32'h0, 4'h0, 1);
        tbl[12] = mk("lh_mis", 1, 0, 3'b001, 32'h0000_0103, 32'h0, 32'hF234_5678, 5'd13, 0, 0, 32'h0, 32'h0, 32'h0, 4'h0, 1);
        tbl[13] = mk("sw_mis", 0, 1, 3'b010, 32'h0000_0206, 32'h89AB_CDEF, 32'h0, 5'd2, 0, 0, 32'h0, 32'h0, 32'h0, 4'h0, 1);
`else
        tbl[11] = mk("lw_mis", 1, 0, 3'b010, 32'h0000_0101, 32'h0, 32'hCAFE_F00D, 5'd12, 1, 1, 32'hCAFE_F00D, 32'h100, 32'h0, 4'h0, 0);
        tbl[12] = mk("lh_mis", 1, 0, 3'b001, 32'h0000_0103, 32'h0, 32'hF234_5678, 5'd13, 0, 1, 32'hFFFF_F234, 32'h100, 32'h0, 4'h0, 0);
        tbl[13] = mk("sw_mis", 0, 1, 3'b010, 32'h0000_0206, 32'h89AB_CDEF, 32'h0, 5'd2, 0, 0, 32'h0, 32'h204, 32'h89AB_CDEF, 4'b1111, 0);
`endif
        bub = mk("bubble_rd", 1, 0, 3'b010, 32'h0000_0900, 32'h0, 32'h0, 5'd15, 0, 0, 32'h0, 32'h0, 32'h0, 4'h0, 0);
        bub.valid = 1'b0;
        tbl[14] = bub;
        tbl[15] = mk("alu2",   0, 0, 3'b000, 32'hFFFF_0000, 32'h0, 32'h0, 5'd14, 0, 1, 32'hFFFF_0000, 32'h0, 32'h0, 4'h0, 0);

        rst = 1'b0;
        ex_valid = 1'b0; ex_result = 32'h0; ex_store_data = 32'h0; ex_dest = 5'd0;
        ex_write_enable = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0; ex_funct3 = 3'b000;
        dbus_ack = 1'b0; dbus_rdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        exp_q.push_back(rst_item());
        wb_exp   = rst_item();
        wb_check = 1'b1;

        for (int i = 0; i < 16; i++) begin
            issue_q.push_back(tbl[i]);
            drain();
        end
        repeat (3) step(1'b0, 1'b0);

        // Back-to-back LW then SW, both acked in their first BUS cycle.
        b2b = 0;
        issue_q.push_back(mk("lw_b2b", 1, 0, 3'b010, 32'h0000_0700, 32'h0, 32'h0BAD_F00D, 5'd16, 0, 1, 32'h0BAD_F00D, 32'h700, 32'h0, 4'h0, 0));
        issue_q.push_back(mk("sw_b2b", 0, 1, 3'b010, 32'h0000_0704, 32'h7654_3210, 32'h0, 5'd17, 0, 0, 32'h0, 32'h704, 32'h7654_3210, 4'b1111, 0));
        drain();
        repeat (3) step(1'b0, 1'b0);
        chk("b2b_req_no_gap", 32'(b2b >= 1), 32'h1);

        // Reset during a pending LW abandons it; a late ack afterwards is ignored.
        issue_q.push_back(mk("lw_abort", 1, 0, 3'b010, 32'h0000_0800, 32'h0, 32'h1111_2222, 5'd18, 5, 1, 32'h1111_2222, 32'h800, 32'h0, 4'h0, 0));
        drain();
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        repeat (2) step(1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage RV32I pipeline, between EX and register writeback. Registers the EX result, performs loads and stores over a single-outstanding req/ack data bus with byte/half/word alignment and sign extension, and stalls upstream while an access is pending. It is the producer of the `mem_*` and `wb_*` forwarding signals consumed by EX.

## Interface
Parameters:
- `RESET_DEST`, default 0: reset value of `mem_dest` and `wb_dest`.

Ports:
- `clk` input 1: pipeline clock.
- `rst` input 1: synchronous reset, active-low. One clock.
- `ex_valid` input 1: EX holds a valid instruction.
- `ex_result` input 32: ALU result; the effective address for loads and stores.
- `ex_store_data` input 32: forwarded rs2 (`corrected_operand2`).
- `ex_dest` input 5: destination register.
- `ex_write_enable` input 1: instruction writes rd.
- `ex_mem_read` / `ex_mem_write` input 1 each: load / store.
- `ex_funct3` input 3: size/sign (000 B, 001 H, 010 W, 100 BU, 101 HU).
- `stall` output 1: freeze IF/ID/EX this cycle.
- `dbus_req` output 1, `dbus_we` output 1, `dbus_addr` output 32, `dbus_wdata` output 32, `dbus_wstrb` output 4: data bus request.
- `dbus_ack` input 1, `dbus_rdata` input 32: data bus response.
- `mem_dest` output 5, `mem_write_enable` output 1, `mem_data` output 32: MEM-slot forwarding.
- `wb_dest` output 5, `wb_write_enable` output 1, `wb_data` output 32: writeback and WB forwarding.
- `misalign_err` output 1: present only with `MEM_MISALIGN_TRAP_EN`.

## Operation
- There are two register slots, MEM and WB. The FSM has two states, IDLE and BUS.
- Slot capture: the MEM slot loads from EX at the rising edge when `!stall`. If `ex_valid=0`, it loads a bubble (write enable 0, no memory op).
- Entering BUS: capturing a load or store moves the FSM to BUS. Otherwise it is IDLE.
- In BUS:
  - `dbus_req=1`. `dbus_addr` is `{result[31:2],2'b00}`.
  - `dbus_wstrb`/`dbus_wdata` come from the size and `addr[1:0]`: SB replicates the byte, so strobe is `0001<<a`. SH replicates the half, so strobe is `0011<<a`. SW uses strobe `1111`.
  - All bus outputs are held stable until ack.
- Leaving BUS: `dbus_ack=1` in BUS completes the access. At that edge the slot advances to WB and the FSM goes to BUS or IDLE, depending on the newly captured instruction.
- `stall = (state==BUS) && !dbus_ack`.
- Load data: select the byte/half of `dbus_rdata` by `addr[1:0]`, then sign-extend (B/H) or zero-extend (BU/HU).
- `mem_data`:
  - Non-load: the slot result.
  - Load in the ack cycle: the extended load data.
  - `mem_write_enable` is 0 for a load before ack.
- `wb_data` registers `mem_data` when the slot advances. `wb_*` hold while stalled.
- Writes to x0: any write enable is forced to 0 when its dest is 0.
- `dbus_ack` outside BUS is ignored.
- Stores never set write enable.

## Timing
- Reset (`rst=0` at an edge):
  - FSM goes to IDLE and both slots are emptied.
  - `dbus_req`, `dbus_we`, `dbus_wstrb`, `stall`, both write enables and `misalign_err` are 0.
  - Data/address outputs are 0. Dests are `RESET_DEST`.
- Reset during BUS abandons the access: `dbus_req=0` from the next cycle.
- Non-memory latency: one cycle through MEM, one through WB. No stall.
- Load/store latency: 1 + k cycles in MEM for an ack at wait cycle k (k≥0). A zero-wait ack, in the first BUS cycle, gives no stall.
- Back-to-back memory ops: the ack cycle captures the next op, so `dbus_req` stays high with a new address and there is no idle cycle.

## Configuration
- `MEM_MISALIGN_TRAP_EN` defined:
  - A halfword at `addr[0]=1`, or a word at `addr[1:0]≠0`, issues no bus request and does not stall.
  - The instruction's write enable is cleared.
  - `misalign_err` pulses for one cycle, registered alongside WB.
- `MEM_MISALIGN_TRAP_EN` undefined:
  - The offending low address bits are forced to natural alignment (H: `a&2`, W: 0).
  - The `misalign_err` port is absent.

## Structure
- The shared package `rv_pkg` holds:
  - the funct3 size constants (`F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`);
  - the FSM state enum `mem_state_t`;
  - the x0 index constant.
- One natural sub-module, `load_align`, is combinational: `rdata`, `addr[1:0]`, `funct3` → extended 32-bit data.

## Test plan
- ALU op, `ex_result=32'h1234`, `ex_dest=5` → next cycle `mem_data=32'h1234`, `mem_write_enable=1`; one cycle later `wb_data=32'h1234`, `wb_dest=5`; `stall` stays 0.
- LB at addr `0x103`, `dbus_rdata=32'h80FF_FF7F`, ack after 2 wait cycles → `stall=1` for 2 cycles, `dbus_addr=0x100`, `wb_data=32'hFFFF_FF80`; the LBU variant gives `32'h0000_0080`.
- SH at addr `0x202` with data `32'hAAAA_BEEF`, zero-wait ack → `dbus_we=1`, `dbus_wstrb=4'b1100`, `dbus_wdata=32'hBEEF_BEEF`, no stall, `wb_write_enable=0`.
- LW then SW back-to-back, ack in each first BUS cycle → `dbus_req` stays high for 2 consecutive cycles with 2 distinct addresses.
- `rst=0` asserted during the BUS wait of an LW → next cycle `dbus_req=0`, `stall=0`, all write enables 0; a late `dbus_ack` is ignored.
- LW at `0x101`:
  - With `MEM_MISALIGN_TRAP_EN`: `misalign_err` pulses once, no `dbus_req`, `wb_write_enable=0`.
  - Without it: access at `0x100`.
